// File: rtl/ifetch_prefetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches, buffers returned
// words with their PCs in an in-order prefetch queue, and flushes on redirect.
module ifetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc
);

    localparam int          CW  = $clog2(DEPTH + 1);
    localparam int          AW  = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   r_q_inst [DEPTH];
    logic [31:0]   r_q_pc   [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_drop;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;

    logic [CW:0]   w_credit;
    logic          w_req;
    logic          w_issue;
    logic          w_rsp;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_redir_pc;

    // Every queued entry and every in-flight request (dropped or not) holds a
    // credit, so a returning word always finds a free slot.
    assign w_credit   = {1'b0, r_count} + {1'b0, r_outst};
    assign w_req      = reset && !redirect && (w_credit < (CW+1)'(DEPTH));
    assign w_issue    = w_req && imem_gnt;
    assign w_rsp      = imem_rvalid && (r_outst != '0);
    assign w_push     = w_rsp && (r_drop == '0) && !redirect;
    assign w_pop      = (r_count != '0) && !stall && !redirect;
    assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;

    assign imem_req   = w_req;
    assign imem_addr  = r_fetch_pc;
    assign inst_valid = (r_count != '0);
    assign inst       = inst_valid ? r_q_inst[r_rptr] : NOP;
    assign pc         = inst_valid ? r_q_pc[r_rptr]   : 32'h0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_inst[r_wptr] <= imem_rdata;
            r_q_pc[r_wptr]   <= r_resp_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_outst    <= '0;
            r_drop     <= '0;
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
        end else if (redirect) begin
            // Everything still in flight, minus a word returning right now,
            // must be discarded when it arrives.
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_outst    <= r_outst - CW'(w_rsp);
            r_drop     <= r_outst - CW'(w_rsp);
            r_fetch_pc <= w_redir_pc;
            r_resp_pc  <= w_redir_pc;
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_outst <= r_outst + CW'(w_issue) - CW'(w_rsp);
            if (w_rsp) begin
                if (r_drop != '0) begin
                    r_drop <= r_drop - CW'(1);
                end else begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
            end
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Directed bench for ifetch_prefetch_queue: an in-order memory responder plus a
// scoreboard of expected PCs pushed on grant and popped when decode consumes.
module tb_ifetch_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;

    ifetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .pc          (pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        logic        live;
    } rsp_t;

    rsp_t        resp_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] popped[$];
    logic [31:0] popped_inst[$];
    int          pop_cyc[$];

    int          errors = 0;
    int          checks = 0;
    int          held   = 0;
    int          cyc    = 0;
    logic [31:0] tb_fpc = RESET_PC;
    logic        rsp_en = 1'b1;
    logic        stray  = 1'b0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_inst, s_pc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        resp_q.delete();
        exp_q.delete();
        held   = 0;
        tb_fpc = RESET_PC;
    endtask

    // One clock: drive the responder, sample mid-cycle, check, advance model.
    task automatic cycle();
        logic        did_rsp;
        logic        exp_req;
        logic [31:0] e;
        rsp_t        r;
        imem_rvalid = (rsp_en && resp_q.size() != 0) || stray;
        imem_rdata  = (resp_q.size() != 0) ? memf(resp_q[0].addr) : 32'hBAD0_BAD0;
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = inst_valid;
        s_inst  = inst;
        s_pc    = pc;
        exp_req = reset && !redirect && ((held + resp_q.size()) < DEPTH);
        chk("req", {31'b0, s_req}, {31'b0, exp_req});
        chk("addr", s_addr, tb_fpc);
        chk("inst_valid", {31'b0, s_valid}, {31'b0, held != 0});
        if (!s_valid) begin
            chk("idle_inst", s_inst, NOP);
            chk("idle_pc", s_pc, 32'h0);
        end
        did_rsp = imem_rvalid && resp_q.size() != 0;
        if (s_valid && !stall && !redirect) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            chk("pop_pc", s_pc, e);
            chk("pop_inst", s_inst, memf(e));
            popped.push_back(s_pc);
            popped_inst.push_back(s_inst);
            pop_cyc.push_back(cyc);
            if (held > 0) held--;
        end
        if (redirect) begin
            foreach (resp_q[i]) resp_q[i].live = 1'b0;
            exp_q.delete();
            held   = 0;
            tb_fpc = redirect_pc & 32'hFFFF_FFFC;
        end
        if (did_rsp) begin
            r = resp_q.pop_front();
            if (r.live) held++;
        end
        if (s_req && imem_gnt) begin
            resp_q.push_back('{addr: tb_fpc, live: 1'b1});
            exp_q.push_back(tb_fpc);
            tb_fpc = tb_fpc + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        imem_gnt = 1'b0;
        n = 0;
        while ((resp_q.size() != 0 || held != 0) && n < 30) begin
            cycle();
            n++;
        end
        chk("drain_in_time", {31'b0, n < 30}, 32'd1);
    endtask

    initial begin
        int          n;
        int          bad;
        logic [31:0] a0;
        logic [31:0] h_pc, h_inst;

        reset       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        model_reset();
        @(negedge clk);
        cycle();
        cycle();
        chk("rst_valid", {31'b0, s_valid}, 32'd0);
        chk("rst_inst", s_inst, NOP);
        chk("rst_pc", s_pc, 32'h0);
        chk("rst_req", {31'b0, s_req}, 32'd0);
        chk("rst_addr", s_addr, RESET_PC);

        // Streaming from reset release, single-cycle memory latency.
        reset    = 1'b1;
        imem_gnt = 1'b1;
        popped.delete();
        pop_cyc.delete();
        cycle();
        chk("t1_first_req", {31'b0, s_req}, 32'd1);
        n = 0;
        while (!s_valid && n < 10) begin
            cycle();
            n++;
        end
        chk("t1_latency", n, 32'd2);
        repeat (4) cycle();
        chk("t1_npop", {31'b0, popped.size() >= 4}, 32'd1);
        if (popped.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("t1_pc_seq", popped[i], 32'(i * 4));
            chk("t1_back_to_back", pop_cyc[3] - pop_cyc[0], 32'd3);
        end

        // Long decode stall: head held, fetch throttled by credits.
        stall = 1'b1;
        cycle();
        h_pc   = s_pc;
        h_inst = s_inst;
        chk("t2_valid_at_stall", {31'b0, s_valid}, 32'd1);
        repeat (7) begin
            cycle();
            chk("t2_hold_pc", s_pc, h_pc);
            chk("t2_hold_inst", s_inst, h_inst);
        end
        chk("t2_req_throttled", {31'b0, s_req}, 32'd0);
        stall = 1'b0;
        popped.delete();
        repeat (16) cycle();
        chk("t2_npop", {31'b0, popped.size() >= 8}, 32'd1);
        chk("t2_resume_pc", (popped.size() != 0) ? popped[0] : 32'hxxxx_xxxx, h_pc);
        bad = 0;
        for (int i = 1; i < popped.size(); i++)
            if (popped[i] != popped[i-1] + 32'd4) bad++;
        chk("t2_no_gap_dup", bad, 32'd0);

        // Redirect with two requests outstanding and unaligned target.
        drain();
        rsp_en   = 1'b0;
        imem_gnt = 1'b1;
        cycle();
        cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        cycle();
        chk("t3_redir_req", {31'b0, s_req}, 32'd0);
        redirect = 1'b0;
        rsp_en   = 1'b1;
        popped.delete();
        popped_inst.delete();
        n = 0;
        while (popped.size() == 0 && n < 20) begin
            cycle();
            n++;
        end
        chk("t3_pc", (popped.size() != 0) ? popped[0] : 32'hxxxx_xxxx, 32'h0000_0100);
        chk("t3_inst", (popped_inst.size() != 0) ? popped_inst[0] : 32'hxxxx_xxxx, memf(32'h0000_0100));

        // Stray rvalid with nothing outstanding, then grant withheld 3 cycles.
        drain();
        stray = 1'b1;
        cycle();
        stray = 1'b0;
        cycle();
        a0 = s_addr;
        chk("t4_req0", {31'b0, s_req}, 32'd1);
        repeat (2) begin
            cycle();
            chk("t4_req_held", {31'b0, s_req}, 32'd1);
            chk("t4_addr_held", s_addr, a0);
        end
        imem_gnt = 1'b1;
        cycle();
        cycle();
        chk("t4_addr_after_gnt", s_addr, a0 + 32'd4);

        // Asynchronous reset while the queue holds entries.
        stall = 1'b1;
        repeat (3) cycle();
        chk("t5_pre_valid", {31'b0, s_valid}, 32'd1);
        reset = 1'b0;
        model_reset();
        cycle();
        chk("t5_valid", {31'b0, s_valid}, 32'd0);
        chk("t5_inst", s_inst, NOP);
        chk("t5_pc", s_pc, 32'h0);
        chk("t5_req", {31'b0, s_req}, 32'd0);
        stall = 1'b0;
        reset = 1'b1;
        cycle();
        chk("t5_first_req", {31'b0, s_req}, 32'd1);
        chk("t5_first_addr", s_addr, RESET_PC);

        // Redirect near the top of the address space, mid-stream.
        repeat (2) cycle();
        popped.delete();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        cycle();
        redirect = 1'b0;
        n = 0;
        while (popped.size() < 3 && n < 30) begin
            cycle();
            n++;
        end
        chk("t6_pc0", (popped.size() > 0) ? popped[0] : 32'hxxxx_xxxx, 32'hFFFF_FFF8);
        chk("t6_pc1", (popped.size() > 1) ? popped[1] : 32'hxxxx_xxxx, 32'hFFFF_FFFC);
        chk("t6_pc2", (popped.size() > 2) ? popped[2] : 32'hxxxx_xxxx, 32'h0000_0000);

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
